// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point complex frame bank: frame geometry,
// streamer state encoding and the 4-bit index bit-reversal helper.
package fft_pkg;

  localparam int N_POINTS = 16;
  localparam int IDX_W    = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Reverse the four bits of a bank index (0,1,2,3 -> 0,8,4,12).
  function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] c);
    return {c[0], c[1], c[2], c[3]};
  endfunction

endpackage

// File: rtl/signal_frame_streamer_if.sv
// Frame load / sample stream bundle for signal_frame_streamer.
// master: the environment (frame source and sample consumer).
// slave : the streamer itself.
interface signal_frame_streamer_if
  import fft_pkg::*;
#(
  parameter int WORD_SIZE = 16
);

  logic                          load;
  logic [N_POINTS*WORD_SIZE-1:0] in_re;
  logic [N_POINTS*WORD_SIZE-1:0] in_im;
  logic                          out_valid;
  logic                          out_ready;
  logic [WORD_SIZE-1:0]          out_re;
  logic [WORD_SIZE-1:0]          out_im;
  logic [IDX_W-1:0]              out_idx;
  logic                          out_last;
  logic                          busy;
  logic                          dropped;

  modport master (
    output load, in_re, in_im, out_ready,
    input  out_valid, out_re, out_im, out_idx, out_last, busy, dropped
  );

  modport slave (
    input  load, in_re, in_im, out_ready,
    output out_valid, out_re, out_im, out_idx, out_last, busy, dropped
  );

endinterface

// File: rtl/frame_bank_mux.sv
// 16-entry complex register file: synchronous parallel write of a whole
// frame, combinational 4-bit indexed read.
module frame_bank_mux
  import fft_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [N_POINTS*WORD_SIZE-1:0] wr_re,
  input  logic [N_POINTS*WORD_SIZE-1:0] wr_im,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic [WORD_SIZE-1:0]          rd_re,
  output logic [WORD_SIZE-1:0]          rd_im
);

  logic [WORD_SIZE-1:0] re_q [N_POINTS];
  logic [WORD_SIZE-1:0] im_q [N_POINTS];

  // Capture the whole frame in one cycle when we is high.
  // NOTE: the bank is cleared on reset so the idle outputs read back as zero
  // after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_POINTS; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else if (we) begin
      for (int k = 0; k < N_POINTS; k++) begin
        re_q[k] <= wr_re[k*WORD_SIZE +: WORD_SIZE];
        im_q[k] <= wr_im[k*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  assign rd_re = re_q[rd_idx];
  assign rd_im = im_q[rd_idx];

endmodule

// File: rtl/signal_frame_streamer.sv
// Reader side of the 16-point complex frame bank. Captures a parallel frame
// on load and streams it one sample per beat over valid/ready.
// Optional build macro: SIGNAL_STREAM_BITREV_EN selects bit-reversed read
// order (0,8,4,12,...); the default build reads in natural order.
module signal_frame_streamer
  import fft_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  signal_frame_streamer_if.slave bus
);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 dropped_q, dropped_d;
  logic                 capture;
  logic                 transfer;
  logic                 at_last;
  logic [IDX_W-1:0]     rd_idx;
  logic [WORD_SIZE-1:0] rd_re, rd_im;

  assign transfer = (state_q == STREAM) && bus.out_ready;
  assign at_last  = (cnt_q == IDX_W'(N_POINTS - 1));

  // Next state, beat counter, frame capture and dropped-load detection.
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    dropped_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (transfer && !at_last) begin
          cnt_d = cnt_q + IDX_W'(1);
        end else if (transfer && at_last) begin
          if (bus.load) begin
            // Back-to-back frame: recapture on the final beat, no bubble.
            capture = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        if (bus.load && !capture) dropped_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and dropped-pulse registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dropped_q <= dropped_d;
    end
  end

`ifdef SIGNAL_STREAM_BITREV_EN
  assign rd_idx = bitrev4(cnt_q);
`else
  assign rd_idx = cnt_q;
`endif

  frame_bank_mux #(
    .WORD_SIZE (WORD_SIZE)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (capture),
    .wr_re  (bus.in_re),
    .wr_im  (bus.in_im),
    .rd_idx (rd_idx),
    .rd_re  (rd_re),
    .rd_im  (rd_im)
  );

  // The counter holds at its last value in IDLE and the bank is untouched,
  // so data/index outputs keep showing the last sample until the next load.
  assign bus.out_valid = (state_q == STREAM);
  assign bus.busy      = (state_q == STREAM);
  assign bus.out_last  = (state_q == STREAM) && at_last;
  assign bus.out_re    = rd_re;
  assign bus.out_im    = rd_im;
  assign bus.out_idx   = rd_idx;
  assign bus.dropped   = dropped_q;

endmodule

// File: doc/signal_frame_streamer.md
Name: signal_frame_streamer

Overview:
- Reader side of the 16-point complex frame bank.
- Captures one parallel frame of 16 complex words (re/im, WORD_SIZE each) on a load strobe, then streams them out one sample per beat over a valid/ready interface.
- Sits between the FFT frame-capture register stage and serial consumers (UART/DAC formatter, downstream DSP).

Parameters:
- WORD_SIZE, 16, width of each real and each imaginary word (two's complement).
- N_POINTS, 16, frame length. Fixed at 16; the index width is 4.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; capture in_re/in_im into the frame buffer.
- in_re  in  16*WORD_SIZE  flat real words; word k is in_re[k*WORD_SIZE +: WORD_SIZE].
- in_im  in  16*WORD_SIZE  flat imaginary words, same packing as in_re.
- out_valid  out  1  a sample is presented.
- out_ready  in  1  the consumer accepts the sample; a beat transfers when out_valid & out_ready.
- out_re  out  WORD_SIZE  real part of the current sample.
- out_im  out  WORD_SIZE  imaginary part of the current sample.
- out_idx  out  4  bank index of the current sample.
- out_last  out  1  high with the final sample of the frame.
- busy  out  1  high while a frame is being streamed.
- dropped  out  1  one-cycle pulse when a load is ignored.

Behaviour:
- Reset values, all asynchronous on rst_n low:
  - frame buffer = 0, beat counter = 0, state = IDLE.
  - out_valid = 0, busy = 0, dropped = 0, out_idx = 0, out_last = 0, out_re = 0, out_im = 0.
- Reset mid-stream aborts the frame immediately; there is no partial continuation after release.
- FSM has two states: IDLE and STREAM.
  - IDLE & load: capture all 32 words, beat counter = 0, go to STREAM.
  - STREAM: out_valid = 1 and busy = 1.
  - On a transfer with counter < 15: counter increments.
  - On a transfer with counter = 15 and load = 0: go to IDLE.
  - On a transfer with counter = 15 and load = 1: recapture, counter = 0, stay in STREAM. This gives back-to-back frames with no bubble.
  - load in STREAM at any other time: ignored, buffer untouched, dropped pulses for 1 cycle.
- Latency and outputs:
  - load in cycle N gives out_valid = 1 with sample 0 in cycle N+1.
  - An idle consumer sees at most one sample per cycle; a full frame takes 16 beats at out_ready = 1.
  - out_re, out_im, out_idx and out_last are functions of registered state only; there is no combinational path from in_* or load.
  - They hold stable while out_valid & !out_ready; stalls of any length are legal.
  - out_valid never deasserts before its beat transfers.
  - out_last = 1 exactly when out_valid is high and the counter = 15.
- Data path: words pass through unmodified. No scaling and no reordering beyond the read order below.
- Default read order is natural: out_idx = counter (0..15).
- In IDLE, out_re, out_im and out_idx hold their last values; consumers qualify by out_valid.

Optional Feature:
- Macro SIGNAL_STREAM_BITREV_EN.
- Defined: the read order is bit-reversed, out_idx = {c[0],c[1],c[2],c[3]} for counter c. The sequence is 0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15. out_last is still tied to counter = 15, i.e. out_idx = 15.
- Not defined: natural order only; no reversal logic is synthesised.

Decomposition:
- Shared package fft_pkg holds:
  - N_POINTS = 16 and IDX_W = 4.
  - State encoding typedef (IDLE, STREAM).
  - bitrev4 function.
- One sub-module is natural: frame_bank_mux, the 16-entry complex register file with synchronous parallel write and 4-bit indexed read.
- The FSM, counter and handshake stay in signal_frame_streamer.

Test Plan:
- Ramp: load in_re[k] = k, in_im[k] = -k, with out_ready = 1. Expect 16 beats starting 1 cycle after load, (re, im) = (0,0), (1,-1) … (15,-15), out_last on beat 15, then out_valid = 0.
- Stall: same frame, out_ready low for 5 cycles at beat 3. Expect out_re = 3, out_idx = 3 held stable the whole stall; no beat is lost or duplicated.
- Back-to-back: second frame (in_re[k] = 100+k) loaded in the same cycle as the beat-15 transfer. Expect out_valid to stay high and the next beat to be re = 100.
- Dropped load: pulse load at beat 7 with different data. Expect dropped = 1 for 1 cycle and the remaining beats to still come from the original frame (re = 7..15).
- Reset mid-stream: assert rst_n low at beat 5. Expect all outputs 0 immediately and out_valid = 0 after release until the next load.
- With SIGNAL_STREAM_BITREV_EN and a ramp frame: expect the out_re sequence 0, 8, 4, 12 … 7, 15, with out_idx matching out_re.
